// File: rtl/gb_freq_calc.sv
// MIDI note + vibrato word -> 11-bit Game Boy frequency register value.
// Sequential octave divide, octave ROM lookup, shift-add vibrato scaling.
module gb_freq_calc #(
   parameter int unsigned VIB_DEPTH  = 4,
   parameter int unsigned VIB_CENTER = 12
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        note_on,
   input  logic [6:0]  note,
   input  logic [8:0]  vib_in,
   output logic [10:0] freq_out,
   output logic        freq_valid,
   output logic        trig,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIV,
      S_LOOKUP,
      S_MUL,
      S_APPLY
   } state_t;

   state_t state, state_nx;

   logic [6:0]  last_note;
   logic [8:0]  last_vib;
   logic        gate_d;
   logic        new_note_flag;
   logic [6:0]  rem;
   logic [2:0]  oct;
   logic [4:0]  s_mag;
   logic        s_pos;
   logic        s_neg;
   logic [10:0] p_reg;
   logic [10:0] delta_reg;
   logic [2:0]  mul_cnt;
   logic [15:0] acc;

   logic               start;
   logic               abort;
   logic [6:0]         note_cl;
   logic [4:0]         vib_cl;
   logic signed [6:0]  s_c;
   logic [6:0]         s_abs;
   logic [10:0]        p_lk;
   logic [10:0]        pn_lk;
   logic [19:0]        scaled;
   logic [12:0]        offset;
   logic signed [14:0] pout;
   logic [11:0]        pout_cl;
   logic [11:0]        freq_full;

   function automatic logic [10:0] oct_rom(input logic [3:0] i);
      case (i)
         4'd0:    oct_rom = 11'd2004;
         4'd1:    oct_rom = 11'd1891;
         4'd2:    oct_rom = 11'd1785;
         4'd3:    oct_rom = 11'd1685;
         4'd4:    oct_rom = 11'd1591;
         4'd5:    oct_rom = 11'd1501;
         4'd6:    oct_rom = 11'd1417;
         4'd7:    oct_rom = 11'd1337;
         4'd8:    oct_rom = 11'd1262;
         4'd9:    oct_rom = 11'd1192;
         4'd10:   oct_rom = 11'd1125;
         4'd11:   oct_rom = 11'd1062;
         default: oct_rom = 11'd1002;
      endcase
   endfunction

   assign busy  = (state != S_IDLE);
   assign start = (state == S_IDLE) && en && note_on &&
                  ((note != last_note) || (vib_in != last_vib) || !gate_d);
   assign abort = (state != S_IDLE) && (!en || !note_on);

   always_comb begin
      note_cl = note;
      if (note < 7'd36)
         note_cl = 7'd36;
      else if (note > 7'd119)
         note_cl = 7'd119;
      vib_cl = (vib_in > 9'd24) ? 5'd24 : vib_in[4:0];
      s_c    = $signed({2'b00, vib_cl}) - $signed(7'(VIB_CENTER));
      s_abs  = s_c[6] ? $unsigned(-s_c) : $unsigned(s_c);
   end

   always_comb begin
      p_lk  = oct_rom(rem[3:0]) >> oct;
      pn_lk = oct_rom(rem[3:0] + 4'd1) >> oct;
   end

   // Positive s raises pitch, i.e. shortens the period.
   always_comb begin
      scaled = 20'(acc) * 20'(VIB_DEPTH);
      offset = scaled[19:7];
      if (s_pos)
         pout = $signed({4'b0000, p_reg}) - $signed({2'b00, offset});
      else if (s_neg)
         pout = $signed({4'b0000, p_reg}) + $signed({2'b00, offset});
      else
         pout = $signed({4'b0000, p_reg});
      if (pout < 15'sd1)
         pout_cl = 12'd1;
      else if (pout > 15'sd2048)
         pout_cl = 12'd2048;
      else
         pout_cl = pout[11:0];
      freq_full = 12'd2048 - pout_cl;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = S_DIV;
         S_DIV:    if (rem < 7'd12) state_nx = S_LOOKUP;
         S_LOOKUP: state_nx = S_MUL;
         S_MUL:    if (mul_cnt == 3'd4) state_nx = S_APPLY;
         S_APPLY:  state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (abort)
         state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freq_out      <= '0;
         freq_valid    <= 1'b0;
         trig          <= 1'b0;
         last_note     <= 7'h7F;
         last_vib      <= 9'd12;
         gate_d        <= 1'b0;
         new_note_flag <= 1'b0;
         rem           <= '0;
         oct           <= '0;
         s_mag         <= '0;
         s_pos         <= 1'b0;
         s_neg         <= 1'b0;
         p_reg         <= '0;
         delta_reg     <= '0;
         mul_cnt       <= '0;
         acc           <= '0;
      end else begin
         freq_valid <= 1'b0;
         trig       <= 1'b0;
         if (en)
            gate_d <= note_on;
         // An aborted note forgets its pitch so the next gate always retriggers.
         if (abort) begin
            last_note <= 7'h7F;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     last_note     <= note;
                     last_vib      <= vib_in;
                     new_note_flag <= (note != last_note) || !gate_d;
                     rem           <= note_cl - 7'd36;
                     oct           <= '0;
                     s_mag         <= s_abs[4:0];
                     s_pos         <= !s_c[6] && (s_c != 7'sd0);
                     s_neg         <= s_c[6];
                  end
               end
               S_DIV: begin
                  if (rem >= 7'd12) begin
                     rem <= rem - 7'd12;
                     oct <= oct + 3'd1;
                  end
               end
               S_LOOKUP: begin
                  p_reg     <= p_lk;
                  delta_reg <= p_lk - pn_lk;
                  acc       <= '0;
                  mul_cnt   <= '0;
               end
               S_MUL: begin
                  if (s_mag[mul_cnt])
                     acc <= acc + (16'(delta_reg) << mul_cnt);
                  mul_cnt <= mul_cnt + 3'd1;
               end
               S_APPLY: begin
                  freq_out   <= freq_full[10:0];
                  freq_valid <= 1'b1;
                  trig       <= new_note_flag;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
